// File: rtl/lisnoc_router_output_arbiter_burst_pkg.sv
// Shared encodings for the burst output arbiter: flit types and arbiter states.
package lisnoc_router_output_arbiter_burst_pkg;

    typedef enum logic [1:0] {
        FlitPayload = 2'b00,
        FlitHeader  = 2'b01,
        FlitLast    = 2'b10,
        FlitSingle  = 2'b11
    } flit_type_e;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StBurst = 1'b1
    } arb_state_e;

    function automatic logic is_pkt_end(input logic [1:0] ftype);
        return (ftype == FlitLast) || (ftype == FlitSingle);
    endfunction

endpackage

// File: rtl/lisnoc_rr_search.sv
// Combinational round-robin search: first set request at or after start_i, with wrap-around.
module lisnoc_rr_search #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] start_i,
    output logic            hit_o,
    output logic [IdxW-1:0] idx_o
);

    logic [IdxW-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest request is written last and wins.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        cand  = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            cand = IdxW'((int'(start_i) + i) % int'(N));
            if (req_i[cand]) begin
                hit_o = 1'b1;
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/lisnoc_router_output_arbiter_burst.sv
// Output-port link arbiter with round-robin burst grants over the per-VC FIFOs.
// Optional per-VC grant counters are built when LISNOC_OUTARB_STATS_EN is defined.
module lisnoc_router_output_arbiter_burst
    import lisnoc_router_output_arbiter_burst_pkg::*;
#(
    parameter int unsigned flit_data_width = 32,
    parameter int unsigned flit_type_width = 2,
    parameter int unsigned vchannels       = 4,
    parameter int unsigned max_burst       = 4,
    parameter bit          end_on_last     = 1'b1,
    localparam int unsigned flit_width     = flit_data_width + flit_type_width
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [vchannels-1:0]            fifo_valid_i,
    input  logic [vchannels*flit_width-1:0] fifo_flit_i,
    output logic [vchannels-1:0]            fifo_ready_o,
    output logic [vchannels-1:0]            link_valid_o,
    output logic [flit_width-1:0]           link_flit_o,
    input  logic [vchannels-1:0]            link_ready_i,
`ifdef LISNOC_OUTARB_STATS_EN
    output logic [vchannels*16-1:0]         grant_cnt_o,
`endif
    input  logic                            burst_abort_i
);

    localparam int unsigned ChW  = (vchannels > 1) ? $clog2(vchannels) : 1;
    localparam int unsigned CntW = $clog2(max_burst + 1);

    arb_state_e      state_q, state_d;
    logic [ChW-1:0]  cur_ch_q, cur_ch_d;
    logic [CntW-1:0] burst_cnt_q, burst_cnt_d;

    logic [vchannels-1:0]  serviceable;
    logic [ChW-1:0]        search_start, hit_idx, grant_ch;
    logic                  hit, keep, grant, terminate;
    logic [CntW-1:0]       cnt_next;
    logic [flit_width-1:0] grant_flit;

    assign serviceable  = fifo_valid_i & link_ready_i;
    assign search_start = (cur_ch_q >= ChW'(vchannels - 1)) ? '0 : cur_ch_q + ChW'(1);

    lisnoc_rr_search #(
        .N    (vchannels),
        .IdxW (ChW)
    ) u_rr_search (
        .req_i   (serviceable),
        .start_i (search_start),
        .hit_o   (hit),
        .idx_o   (hit_idx)
    );

    // A stalled burst falls straight through to the search, so another VC gets the link
    // in the same cycle.
    assign keep     = (state_q == StBurst) && serviceable[cur_ch_q];
    assign grant    = keep || hit;
    assign grant_ch = keep ? cur_ch_q : hit_idx;

    assign cnt_next = !keep ? CntW'(1) :
                      (burst_cnt_q == CntW'(max_burst)) ? burst_cnt_q : burst_cnt_q + CntW'(1);

    assign grant_flit = fifo_flit_i[grant_ch*flit_width +: flit_width];

    // Packet-end detection looks at the two low type bits.
    assign terminate = (cnt_next >= CntW'(max_burst))
                    || (end_on_last && is_pkt_end(grant_flit[flit_data_width +: 2]))
                    || burst_abort_i;

    always_comb begin
        fifo_ready_o = '0;
        if (rst && grant) begin
            fifo_ready_o[grant_ch] = 1'b1;
        end
    end

    assign link_valid_o = fifo_ready_o;
    assign link_flit_o  = grant_flit;

    always_comb begin
        state_d     = state_q;
        cur_ch_d    = cur_ch_q;
        burst_cnt_d = burst_cnt_q;
        if (grant) begin
            cur_ch_d    = grant_ch;
            burst_cnt_d = cnt_next;
            state_d     = terminate ? StIdle : StBurst;
        end else begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            cur_ch_q    <= ChW'(vchannels - 1);
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cur_ch_q    <= cur_ch_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

`ifdef LISNOC_OUTARB_STATS_EN
    logic [vchannels*16-1:0] grant_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            grant_cnt_q <= '0;
        end else begin
            for (int v = 0; v < int'(vchannels); v++) begin
                if (link_valid_o[v] && (grant_cnt_q[v*16 +: 16] != 16'hFFFF)) begin
                    grant_cnt_q[v*16 +: 16] <= grant_cnt_q[v*16 +: 16] + 16'd1;
                end
            end
        end
    end

    assign grant_cnt_o = grant_cnt_q;
`endif

`ifndef SYNTHESIS
    a_ready_onehot: assert property (@(posedge clk) $onehot0(fifo_ready_o));
`endif

endmodule

// File: tb/tb_lisnoc_router_output_arbiter_burst.sv
// Scoreboard bench for the burst output arbiter; two instances cover two burst configurations.
module tb_lisnoc_router_output_arbiter_burst;
    import lisnoc_router_output_arbiter_burst_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned TW = 2;
    localparam int unsigned FW = DW + TW;
    localparam int unsigned VC = 4;

    typedef struct packed {
        logic [VC-1:0] oh;
        logic [FW-1:0] flit;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [VC-1:0] valid = '0;
    logic [VC-1:0] ready = '0;
    logic abort = 1'b0;
    logic [TW-1:0] ftype [VC];
    logic [DW-1:0] data_v [VC];
    logic [VC*FW-1:0] fifo_flit;

    logic [VC-1:0] ready_a, lvalid_a, ready_b, lvalid_b;
    logic [FW-1:0] flit_a, flit_b;
`ifdef LISNOC_OUTARB_STATS_EN
    logic [VC*16-1:0] gcnt_a, gcnt_b;
`endif

    exp_t sb_a[$];
    exp_t sb_b[$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        fifo_flit = '0;
        for (int v = 0; v < int'(VC); v++) begin
            fifo_flit[v*FW +: FW] = {ftype[v], data_v[v]};
        end
    end

    // A: max_burst 4, bursts end on LAST/SINGLE.
    lisnoc_router_output_arbiter_burst #(
        .flit_data_width (DW), .flit_type_width (TW), .vchannels (VC),
        .max_burst (4), .end_on_last (1'b1)
    ) u_dut_a (
        .clk (clk), .rst (rst), .fifo_valid_i (valid), .fifo_flit_i (fifo_flit),
        .fifo_ready_o (ready_a), .link_valid_o (lvalid_a), .link_flit_o (flit_a),
        .link_ready_i (ready),
`ifdef LISNOC_OUTARB_STATS_EN
        .grant_cnt_o (gcnt_a),
`endif
        .burst_abort_i (abort)
    );

    // B: max_burst 2, packet boundaries ignored.
    lisnoc_router_output_arbiter_burst #(
        .flit_data_width (DW), .flit_type_width (TW), .vchannels (VC),
        .max_burst (2), .end_on_last (1'b0)
    ) u_dut_b (
        .clk (clk), .rst (rst), .fifo_valid_i (valid), .fifo_flit_i (fifo_flit),
        .fifo_ready_o (ready_b), .link_valid_o (lvalid_b), .link_flit_o (flit_b),
        .link_ready_i (ready),
`ifdef LISNOC_OUTARB_STATS_EN
        .grant_cnt_o (gcnt_b),
`endif
        .burst_abort_i (abort)
    );

    function automatic exp_t mk(input int g);
        exp_t e;
        e.oh   = '0;
        e.flit = '0;
        if (g >= 0) begin
            e.oh   = VC'(1) << g;
            e.flit = {ftype[g], data_v[g]};
        end
        return e;
    endfunction

    task automatic new_data();
        for (int v = 0; v < int'(VC); v++) data_v[v] = $urandom;
    endtask

    task automatic all_payload();
        for (int v = 0; v < int'(VC); v++) ftype[v] = FlitPayload;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        all_payload();
        new_data();
        valid = '1;
        ready = '1;
        @(negedge clk);
        checks++;
        if (lvalid_a !== '0) begin
            failures++; $display("FAIL reset_valid_a got=%b want=0000", lvalid_a);
        end
        checks++;
        if (ready_a !== '0) begin
            failures++; $display("FAIL reset_ready_a got=%b want=0000", ready_a);
        end
        checks++;
        if (ready_b !== '0) begin
            failures++; $display("FAIL reset_ready_b got=%b want=0000", ready_b);
        end
    endtask

    task automatic test_round_robin();
        int ea[10];
        int eb[10];
        exp_t e;
        ea = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2};
        eb = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        do_reset();
        valid = '1; ready = '1; abort = 1'b0; all_payload();
        for (int c = 0; c < 10; c++) begin
            new_data();
            sb_a.push_back(mk(ea[c]));
            sb_b.push_back(mk(eb[c]));
            @(negedge clk);
            e = sb_a.pop_front();
            checks++;
            if (lvalid_a !== e.oh) begin
                failures++; $display("FAIL rr_a_grant cyc=%0d got=%b want=%b", c, lvalid_a, e.oh);
            end
            checks++;
            if (flit_a !== e.flit) begin
                failures++; $display("FAIL rr_a_flit cyc=%0d got=%h want=%h", c, flit_a, e.flit);
            end
            e = sb_b.pop_front();
            checks++;
            if (lvalid_b !== e.oh || ready_b !== e.oh) begin
                failures++;
                $display("FAIL rr_b_grant cyc=%0d got=%b/%b want=%b", c, lvalid_b, ready_b, e.oh);
            end
            checks++;
            if (flit_b !== e.flit) begin
                failures++; $display("FAIL rr_b_flit cyc=%0d got=%h want=%h", c, flit_b, e.flit);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_packet_end();
        logic [3:0] vt [5];
        logic [1:0] t1 [5];
        int ex[5];
        exp_t e;
        vt = '{4'b0110, 4'b0110, 4'b0110, 4'b0100, 4'b0100};
        t1 = '{FlitHeader, FlitPayload, FlitLast, FlitPayload, FlitPayload};
        ex = '{1, 1, 1, 2, 2};
        do_reset();
        ready = '1; abort = 1'b0; all_payload();
        for (int c = 0; c < 5; c++) begin
            new_data();
            valid    = vt[c];
            ftype[1] = t1[c];
            sb_a.push_back(mk(ex[c]));
            @(negedge clk);
            e = sb_a.pop_front();
            checks++;
            if (lvalid_a !== e.oh || ready_a !== e.oh) begin
                failures++;
                $display("FAIL pkt_grant cyc=%0d got=%b/%b want=%b", c, lvalid_a, ready_a, e.oh);
            end
            checks++;
            if (flit_a !== e.flit) begin
                failures++; $display("FAIL pkt_flit cyc=%0d got=%h want=%h", c, flit_a, e.flit);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_no_bubble();
        logic [3:0] rt [6];
        int ex[6];
        exp_t e;
        rt = '{4'b1111, 4'b1110, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
        ex = '{0, 3, 3, 3, 3, 0};
        do_reset();
        valid = 4'b1001; abort = 1'b0; all_payload();
        for (int c = 0; c < 6; c++) begin
            new_data();
            ready = rt[c];
            sb_a.push_back(mk(ex[c]));
            @(negedge clk);
            e = sb_a.pop_front();
            checks++;
            if (lvalid_a !== e.oh || ready_a !== e.oh) begin
                failures++;
                $display("FAIL bubble_grant cyc=%0d got=%b/%b want=%b", c, lvalid_a, ready_a, e.oh);
            end
            checks++;
            if (flit_a !== e.flit) begin
                failures++; $display("FAIL bubble_flit cyc=%0d got=%h want=%h", c, flit_a, e.flit);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_abort();
        logic [3:0] vt [4];
        logic at [4];
        int ex[4];
        exp_t e;
        vt = '{4'b0000, 4'b1100, 4'b1100, 4'b1100};
        at = '{1'b1, 1'b1, 1'b0, 1'b0};
        ex = '{-1, 2, 3, 3};
        do_reset();
        ready = '1; all_payload();
        for (int c = 0; c < 4; c++) begin
            new_data();
            valid = vt[c];
            abort = at[c];
            sb_a.push_back(mk(ex[c]));
            @(negedge clk);
            e = sb_a.pop_front();
            checks++;
            if (lvalid_a !== e.oh || ready_a !== e.oh) begin
                failures++;
                $display("FAIL abort_grant cyc=%0d got=%b/%b want=%b", c, lvalid_a, ready_a, e.oh);
            end
            @(posedge clk); #1;
        end
        abort = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [3:0] vt [4];
        logic rtab [4];
        int ex[4];
        exp_t e;
        vt   = '{4'b0100, 4'b0100, 4'b1111, 4'b1111};
        rtab = '{1'b1, 1'b1, 1'b0, 1'b1};
        ex   = '{2, 2, -1, 0};
        do_reset();
        ready = '1; abort = 1'b0; all_payload();
        for (int c = 0; c < 4; c++) begin
            new_data();
            valid = vt[c];
            rst   = rtab[c];
            sb_a.push_back(mk(ex[c]));
            @(negedge clk);
            e = sb_a.pop_front();
            checks++;
            if (lvalid_a !== e.oh || ready_a !== e.oh) begin
                failures++;
                $display("FAIL mrst_grant cyc=%0d got=%b/%b want=%b", c, lvalid_a, ready_a, e.oh);
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
    endtask

`ifdef LISNOC_OUTARB_STATS_EN
    task automatic test_stats();
        logic [15:0] want;
        do_reset();
        valid = 4'b0010; ready = '1; abort = 1'b0; all_payload();
        repeat (70000) @(posedge clk);
        #1 valid = '0;
        @(negedge clk);
        for (int v = 0; v < int'(VC); v++) begin
            want = (v == 1) ? 16'hFFFF : 16'h0000;
            checks++;
            if (gcnt_a[v*16 +: 16] !== want) begin
                failures++;
                $display("FAIL stats_a vc=%0d got=%h want=%h", v, gcnt_a[v*16 +: 16], want);
            end
            checks++;
            if (gcnt_b[v*16 +: 16] !== want) begin
                failures++;
                $display("FAIL stats_b vc=%0d got=%h want=%h", v, gcnt_b[v*16 +: 16], want);
            end
        end
    endtask
`endif

    initial begin
        #1_500_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        all_payload();
        new_data();
        test_reset();
        test_round_robin();
        test_packet_end();
        test_no_bubble();
        test_abort();
        test_mid_reset();
`ifdef LISNOC_OUTARB_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lisnoc_router_output_arbiter_burst.md
Name: lisnoc_router_output_arbiter_burst

Overview:
- Link-side arbiter for one router output port.
- Selects one of `vchannels` virtual-channel FIFOs per cycle and drives its flit onto the shared physical link.
- Next generation of the single-flit round-robin output arbiter. It adds burst grants: a granted VC keeps the link for up to `max_burst` consecutive flits. A grant may also end early at packet boundaries, or be forced to end.
- Sits between the per-VC output FIFOs and the link to the next hop.

Parameters:
- flit_data_width, 32, flit payload bits
- flit_type_width, 2, flit type bits; `flit_width` = data + type
- vchannels, 4, number of virtual channels; legal range 1..16
- max_burst, 4, maximum consecutive flits granted to one VC; legal range 1..255
- end_on_last, 1, 1 = a burst ends after a LAST or SINGLE flit transfers

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-low (asserted when 0, sampled on rising clk)
- fifo_valid_i  input  vchannels  per-VC flit available
- fifo_flit_i  input  vchannels*flit_width  per-VC flit; VC v occupies bits [(v+1)*flit_width-1 : v*flit_width]
- fifo_ready_o  output  vchannels  one-hot pop strobe to the granted FIFO
- link_valid_o  output  vchannels  one-hot valid toward the next hop; equals fifo_ready_o
- link_flit_o  output  flit_width  flit of the current channel
- link_ready_i  input  vchannels  per-VC downstream ready
- burst_abort_i  input  1  force the current burst to end after this cycle

Behaviour:
- Serviceable set: serviceable[v] = fifo_valid_i[v] & link_ready_i[v].
- Grant path is combinational, with zero latency: a transfer on VC v occurs when link_valid_o[v] is 1.
- During reset (rst = 0):
  - fifo_ready_o and link_valid_o are 0.
  - state goes to IDLE; cur_ch goes to vchannels-1, so VC 0 has first priority after reset.
  - burst_cnt goes to 0.
- link_flit_o is a don't-care whenever no grant is asserted.
- State IDLE:
  - Round-robin search of serviceable, starting at cur_ch+1 modulo vchannels.
  - The first hit h is granted this cycle, cur_ch <= h, and burst_cnt <= 1.
  - Go to BURST unless the burst terminates this cycle (rules below).
  - No hit: no grant and state is unchanged.
- State BURST:
  - If serviceable[cur_ch], grant cur_ch and increment burst_cnt.
  - If cur_ch is not serviceable, the burst ends in the same cycle: do the IDLE search starting at cur_ch+1 and grant any hit immediately. No idle bubble is allowed when another VC is serviceable.
- Burst termination: after a granted transfer, go to IDLE if any of the following hold:
  - burst_cnt reached max_burst;
  - end_on_last = 1 and the flit type is LAST or SINGLE;
  - burst_abort_i = 1.
- burst_abort_i asserted in IDLE has no effect.
- burst_cnt is $clog2(max_burst+1) bits wide and never wraps.
- max_burst = 1 reproduces pure per-flit round robin.
- vchannels = 1: the channel index is 1 bit wide and always 0; the search degenerates to serviceable[0].
- At most one bit of fifo_ready_o is ever set. The implementation carries a simulation-only assertion that checks this one-hot property.
- Reset asserted mid-burst: grants drop in the same cycle. The next state is IDLE with cur_ch = vchannels-1, so a partially sent burst is not resumed with priority.

Optional Feature:
- Macro: LISNOC_OUTARB_STATS_EN.
- Defined:
  - Adds output grant_cnt_o, width vchannels*16.
  - Per-VC saturating counters of transferred flits; they hold at 16'hFFFF.
  - Cleared by reset.
  - Updated on every cycle with link_valid_o[v] = 1.
- Undefined:
  - The port and counters do not exist.
  - Grant behaviour is identical in both builds.

Decomposition:
- Shared package / lisnoc_def.vh holds:
  - flit type encodings: PAYLOAD = 2'b00, HEADER = 2'b01, LAST = 2'b10, SINGLE = 2'b11;
  - state encodings IDLE and BURST.
- Sub-module lisnoc_rr_search:
  - purely combinational;
  - takes a request vector and a start index;
  - returns hit and the index of the first request at or after start, with wrap-around.
  - Reused by later allocators.

Test Plan:
- Reset then all VCs valid and ready, vchannels = 4, max_burst = 2, end_on_last = 0, PAYLOAD flits -> grants 0,0,1,1,2,2,3,3,0,...
- VC1 holds a 3-flit packet HEADER, PAYLOAD, LAST with max_burst = 4, end_on_last = 1; VC2 valid throughout -> VC1 for 3 cycles, VC2 on cycle 4.
- During a VC0 burst, link_ready_i[0] drops at cycle 2 while VC3 is valid -> VC3 granted in the same cycle with no bubble; when VC0 becomes ready again it waits its round-robin turn.
- burst_abort_i pulsed during VC2's first flit with max_burst = 4 -> the next cycle grants VC3 (if serviceable), not VC2.
- rst driven low for 1 cycle mid-burst on VC2 -> outputs 0 that cycle; the first grant afterwards goes to VC0 when all VCs are serviceable.
- With LISNOC_OUTARB_STATS_EN defined: 70000 flits on VC1 -> grant_cnt_o[31:16] = 16'hFFFF and the other counts are 0.
